// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending-machine controller.
// Holds the FSM state encoding, the coin unit, and the credit-width legality check.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } state_e;

    // One coin unit is half a yuan.
    localparam int unsigned UNIT_HALF_YUAN = 1;

    // True when the largest credit reachable (PRICE-1 plus the largest coin) fits in credit_w bits.
    function automatic bit credit_w_ok(input int unsigned price,
                                       input int unsigned coin_w,
                                       input int unsigned credit_w);
        int unsigned max_credit;
        max_credit = price - 32'd1 + (32'd1 << coin_w) - 32'd1;
        return (price >= 32'd1) &&
               (int'($clog2(max_credit + 32'd1)) <= int'(credit_w)) &&
               (int'($clog2(price + 32'd1)) <= int'(credit_w));
    endfunction

endpackage

// File: rtl/vend_ctrl.sv
// Vending-machine controller: accumulates coin credit, pulses coke at PRICE,
// returns change on overpay (when enabled) and refunds credit on cancel.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned PRICE     = 6,
    parameter int unsigned COIN_W    = 2,
    parameter int unsigned CREDIT_W  = 4,
    parameter int unsigned CHANGE_EN = 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                coin_valid,
    input  logic [COIN_W-1:0]   coin_val,
    input  logic                cancel,
    output logic                coke,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_val,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    generate
        if (!credit_w_ok(PRICE, COIN_W, CREDIT_W)) begin : g_param_chk
            $fatal(1, "vend_ctrl: PRICE-1 plus the largest coin does not fit in CREDIT_W bits");
        end
    endgenerate

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    state_e                r_state;
    logic [CREDIT_W-1:0]   r_credit;
    logic                  r_coke;
    logic                  r_chg_vld;
    logic [CREDIT_W-1:0]   r_chg_val;
    logic                  r_coin_rej;
    logic                  r_busy;

    state_e                w_state_nxt;
    logic [CREDIT_W-1:0]   w_credit_nxt;
    logic                  w_coke_nxt;
    logic                  w_chg_vld_nxt;
    logic [CREDIT_W-1:0]   w_chg_val_nxt;
    logic                  w_rej_nxt;
    logic                  w_accept;
    logic [CREDIT_W-1:0]   w_sum;

    assign w_accept = coin_valid && (coin_val != '0);
    assign w_sum    = r_credit + CREDIT_W'(coin_val);

    // Next state and the registered-output values that go with entering it.
    always_comb begin
        w_state_nxt   = r_state;
        w_credit_nxt  = r_credit;
        w_coke_nxt    = 1'b0;
        w_chg_vld_nxt = 1'b0;
        w_chg_val_nxt = '0;
        w_rej_nxt     = 1'b0;
        case (r_state)
            IDLE, COLLECT: begin
                if ((r_state == COLLECT) && cancel) begin
                    w_state_nxt   = REFUND;
                    w_chg_vld_nxt = 1'b1;
                    w_chg_val_nxt = w_accept ? w_sum : r_credit;
                    w_credit_nxt  = '0;
                end else if (w_accept) begin
                    if (w_sum >= PRICE_C) begin
                        w_state_nxt  = VEND;
                        w_coke_nxt   = 1'b1;
                        w_credit_nxt = '0;
                        if ((CHANGE_EN != 0) && (w_sum > PRICE_C)) begin
                            w_chg_vld_nxt = 1'b1;
                            w_chg_val_nxt = w_sum - PRICE_C;
                        end
                    end else begin
                        w_state_nxt  = COLLECT;
                        w_credit_nxt = w_sum;
                    end
                end
            end
            VEND, REFUND: begin
                // Busy for one cycle: coins bounce, cancel has no effect.
                w_state_nxt  = IDLE;
                w_credit_nxt = '0;
                w_rej_nxt    = w_accept;
            end
            default: begin
                w_state_nxt  = IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_credit   <= '0;
            r_coke     <= 1'b0;
            r_chg_vld  <= 1'b0;
            r_chg_val  <= '0;
            r_coin_rej <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_credit   <= w_credit_nxt;
            r_coke     <= w_coke_nxt;
            r_chg_vld  <= w_chg_vld_nxt;
            r_chg_val  <= w_chg_val_nxt;
            r_coin_rej <= w_rej_nxt;
            r_busy     <= (w_state_nxt == VEND) || (w_state_nxt == REFUND);
        end
    end

    assign coke         = r_coke;
    assign change_valid = r_chg_vld;
    assign change_val   = r_chg_val;
    assign coin_rej     = r_coin_rej;
    assign credit       = r_credit;
    assign busy         = r_busy;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: a credit-ledger model predicts per-cycle credit/busy
// and sale/refund/reject events; a separate monitor pops and compares them.
module tb_vend_ctrl;

    localparam int unsigned PRICE    = 6;
    localparam int unsigned COIN_W   = 2;
    localparam int unsigned CREDIT_W = 4;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n;
    logic                coin_valid;
    logic [COIN_W-1:0]   coin_val;
    logic                cancel;
    logic                coke, change_valid, coin_rej, busy;
    logic [CREDIT_W-1:0] change_val, credit;
    logic                nc_coke, nc_change_valid, nc_coin_rej, nc_busy;
    logic [CREDIT_W-1:0] nc_change_val, nc_credit;

    vend_ctrl #(.PRICE(PRICE), .COIN_W(COIN_W), .CREDIT_W(CREDIT_W), .CHANGE_EN(1)) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .coin_valid(coin_valid), .coin_val(coin_val),
        .cancel(cancel), .coke(coke), .change_valid(change_valid), .change_val(change_val),
        .coin_rej(coin_rej), .credit(credit), .busy(busy)
    );

    vend_ctrl #(.PRICE(PRICE), .COIN_W(COIN_W), .CREDIT_W(CREDIT_W), .CHANGE_EN(0)) u_dut_nc (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .coin_valid(coin_valid), .coin_val(coin_val),
        .cancel(cancel), .coke(nc_coke), .change_valid(nc_change_valid), .change_val(nc_change_val),
        .coin_rej(nc_coin_rej), .credit(nc_credit), .busy(nc_busy)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { int idx; int credit; int busy; } cyc_t;
    typedef struct { int idx; int coke; int cv; int cval; int rej; } ev_t;

    cyc_t q_cyc[$];
    ev_t  q_ev[$];
    int   n_cmp, n_fail;
    int   stim_idx, mon_idx;
    int   m_credit, m_acc_total;
    bit   m_locked;
    int   coke_cnt, chg_total;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", name, act, exp, mon_idx, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: scoreboard event not matched (cycle %0d, t=%0t)", name, mon_idx, $time);
    endtask

    // Ledger model: a sale or refund locks the machine for exactly the next cycle.
    task automatic drive_and_model(input bit v, input int val, input bit c);
        bit   acc;
        ev_t  ev;
        cyc_t cy;
        coin_valid = v;
        coin_val   = COIN_W'(val);
        cancel     = c;
        acc     = v && (val != 0);
        ev.idx  = stim_idx;
        ev.coke = 0; ev.cv = 0; ev.cval = 0; ev.rej = 0;
        if (m_locked) begin
            m_locked = 1'b0;
            ev.rej   = acc ? 1 : 0;
        end else if (c && (m_credit > 0)) begin
            if (acc) begin
                m_credit    += val;
                m_acc_total += val;
            end
            ev.cv    = 1;
            ev.cval  = m_credit;
            m_credit = 0;
            m_locked = 1'b1;
        end else if (acc) begin
            m_credit    += val;
            m_acc_total += val;
            if (m_credit >= int'(PRICE)) begin
                ev.coke = 1;
                if (m_credit > int'(PRICE)) begin
                    ev.cv   = 1;
                    ev.cval = m_credit - int'(PRICE);
                end
                m_credit = 0;
                m_locked = 1'b1;
            end
        end
        cy.idx    = stim_idx;
        cy.credit = m_credit;
        cy.busy   = int'(m_locked);
        q_cyc.push_back(cy);
        if ((ev.coke != 0) || (ev.cv != 0) || (ev.rej != 0)) q_ev.push_back(ev);
        stim_idx++;
    endtask

    task automatic step(input bit v, input int val, input bit c);
        @(negedge sys_clk);
        drive_and_model(v, val, c);
    endtask

    // Monitor: per-cycle credit/busy, plus event matching whenever an output pulse appears.
    initial begin : monitor
        cyc_t cy;
        ev_t  ev;
        forever begin
            @(posedge sys_clk);
            #1;
            if (sys_rst_n) begin
                if (q_cyc.size() == 0) begin
                    fail_now("cycle_queue_empty");
                end else begin
                    cy = q_cyc.pop_front();
                    chk("credit", int'(credit), cy.credit);
                    chk("busy", int'(busy), cy.busy);
                    chk("nc_credit", int'(nc_credit), cy.credit);
                    chk("nc_busy", int'(nc_busy), cy.busy);
                end
                if (coke || change_valid || coin_rej) begin
                    if (q_ev.size() == 0) begin
                        chk("unexpected_event", int'({coke, change_valid, coin_rej}), 0);
                    end else begin
                        ev = q_ev.pop_front();
                        chk("event_cycle", mon_idx, ev.idx);
                        chk("coke", int'(coke), ev.coke);
                        chk("change_valid", int'(change_valid), ev.cv);
                        chk("change_val", int'(change_val), ev.cval);
                        chk("coin_rej", int'(coin_rej), ev.rej);
                        chk("nc_coke", int'(nc_coke), ev.coke);
                        chk("nc_change_valid", int'(nc_change_valid), (ev.cv != 0 && ev.coke == 0) ? 1 : 0);
                        chk("nc_change_val", int'(nc_change_val), (ev.coke == 0) ? ev.cval : 0);
                        chk("nc_coin_rej", int'(nc_coin_rej), ev.rej);
                    end
                end else begin
                    if ((q_ev.size() > 0) && (q_ev[0].idx == mon_idx)) begin
                        ev = q_ev.pop_front();
                        fail_now("missed_event");
                    end
                    chk("change_val_idle", int'(change_val), 0);
                    chk("nc_coke_idle", int'(nc_coke), 0);
                end
                if (coke) coke_cnt++;
                if (change_valid) chg_total += int'(change_val);
                mon_idx++;
            end
        end
    end

    initial begin
        sys_rst_n  = 1'b0;
        coin_valid = 1'b0;
        coin_val   = '0;
        cancel     = 1'b0;
        n_cmp = 0; n_fail = 0; stim_idx = 0; mon_idx = 0;
        m_credit = 0; m_acc_total = 0; m_locked = 1'b0;
        coke_cnt = 0; chg_total = 0;

        #50;
        chk("rst_coke", int'(coke), 0);
        chk("rst_change_valid", int'(change_valid), 0);
        chk("rst_change_val", int'(change_val), 0);
        chk("rst_coin_rej", int'(coin_rej), 0);
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);

        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        drive_and_model(1'b0, 0, 1'b0);

        // Exact pay 2,2,2.
        step(1'b1, 2, 1'b0); step(1'b1, 2, 1'b0); step(1'b1, 2, 1'b0);
        step(1'b0, 0, 1'b0); step(1'b0, 0, 1'b0);

        // Overpay 3,2,3: change 2; the no-change instance sells without change.
        step(1'b1, 3, 1'b0); step(1'b1, 2, 1'b0); step(1'b1, 3, 1'b0);
        @(posedge sys_clk);
        #2;
        chk("nc_overpay_coke", int'(nc_coke), 1);
        chk("nc_overpay_change_valid", int'(nc_change_valid), 0);
        step(1'b0, 0, 1'b0);

        // Cancel at credit 4, then cancel with a coin at credit 4.
        step(1'b1, 1, 1'b0); step(1'b1, 3, 1'b0); step(1'b0, 0, 1'b1); step(1'b0, 0, 1'b0);
        step(1'b1, 1, 1'b0); step(1'b1, 3, 1'b0); step(1'b1, 2, 1'b1); step(1'b0, 0, 1'b0);

        // Coin during VEND is rejected.
        step(1'b1, 3, 1'b0); step(1'b1, 3, 1'b0); step(1'b1, 3, 1'b0);
        step(1'b0, 0, 1'b0); step(1'b0, 0, 1'b0);

        // Zero-value coins and idle cancel do nothing.
        step(1'b1, 0, 1'b0); step(1'b1, 0, 1'b1); step(1'b0, 0, 1'b1);

        // Coin and cancel during REFUND: coin rejected, cancel ignored.
        step(1'b1, 2, 1'b0); step(1'b0, 0, 1'b1); step(1'b1, 1, 1'b1); step(1'b0, 0, 1'b0);

        // Reset mid-COLLECT at credit 4 clears credit immediately.
        step(1'b1, 1, 1'b0); step(1'b1, 3, 1'b0);
        @(posedge sys_clk);
        #3;
        sys_rst_n  = 1'b0;
        coin_valid = 1'b0;
        coin_val   = '0;
        cancel     = 1'b0;
        #1;
        chk("async_rst_credit", int'(credit), 0);
        chk("async_rst_coke", int'(coke), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_change_valid", int'(change_valid), 0);
        q_cyc.delete();
        q_ev.delete();
        stim_idx = 0; mon_idx = 0;
        m_credit = 0; m_acc_total = 0; m_locked = 1'b0;
        coke_cnt = 0; chg_total = 0;
        #20;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        drive_and_model(1'b0, 0, 1'b0);

        // Random soak.
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 99) < 50, int'($urandom_range(0, 3)), $urandom_range(0, 99) < 8);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0);
        @(posedge sys_clk);
        #3;

        chk("leftover_cycles", q_cyc.size(), 0);
        chk("leftover_events", q_ev.size(), 0);
        chk("money_balance", coke_cnt * int'(PRICE) + chg_total, m_acc_total - m_credit);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
